hd_mac_tile: RTL and testbench

- Consumer end of the projection/feature tiling stream. It accepts one beat per cycle: an N_SIZE-feature slice and an (N_SIZE+M_SIZE)-bit diagonal projection window.
- It accumulates M_SIZE signed dot products over one full feature vector (Div_SIZE/N_SIZE beats) and emits M_SIZE binarized hypervector bits.
- It signals done back to the tile controller, which answers with tile_reset to start the next M_SIZE-dimension tile.

---
 rtl/hd_pkg.sv | 24 ++
 rtl/hd_beat_adder.sv | 21 ++
 rtl/hd_mac_tile.sv | 128 ++++++++++++
 tb/tb_hd_mac_tile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hd_pkg.sv
// Shared constants, accumulator type and FSM encoding for the hyperdimensional
// MAC tile.
package hd_pkg;
    localparam int DHV_SIZE = 4000;
    localparam int DIV_SIZE = 512;
    localparam int N_SIZE   = 16;
    localparam int M_SIZE   = 16;
    localparam int FTWIDTH  = 8;

    localparam int W_WIDTH = N_SIZE + M_SIZE;
    localparam int BEATS   = DIV_SIZE / N_SIZE;
    localparam int TILES   = DHV_SIZE / M_SIZE;
    localparam int ACC_W   = FTWIDTH + $clog2(DIV_SIZE) + 1;
    localparam int BEAT_W  = $clog2(BEATS);
    localparam int IDX_W   = $clog2(TILES);

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        ACC    = 2'd0,
        DONE   = 2'd1,
        FINISH = 2'd2
    } state_e;
endpackage

// File: rtl/hd_beat_adder.sv
// Signed sum of one beat's features for a single hypervector dimension:
// weight bit 1 adds the feature, weight bit 0 subtracts it.
module hd_beat_adder
    import hd_pkg::*;
(
    input  logic [N_SIZE*FTWIDTH-1:0] features,
    input  logic [N_SIZE-1:0]         weights,
    output logic signed [ACC_W-1:0]   sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_SIZE; i++) begin
            if (weights[i])
                sum = sum + $signed({{(ACC_W-FTWIDTH){1'b0}}, features[i*FTWIDTH +: FTWIDTH]});
            else
                sum = sum - $signed({{(ACC_W-FTWIDTH){1'b0}}, features[i*FTWIDTH +: FTWIDTH]});
        end
    end

endmodule

// File: rtl/hd_mac_tile.sv
// Accumulates M_SIZE signed dot products over one feature vector and emits the
// binarized tile, handshaking done / in_tile_reset with the tile controller.
module hd_mac_tile
    import hd_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_in,
    input  logic [W_WIDTH-1:0]        in_projections,
    input  logic [N_SIZE*FTWIDTH-1:0] in_features,
    input  logic                      in_valid,
    input  logic                      in_tile_reset,
    input  logic                      in_all_done,
    output logic                      done,
    output logic [M_SIZE-1:0]         out_hv_bits,
    output logic                      out_hv_valid,
    output logic [IDX_W-1:0]          out_hv_index,
    output logic                      finished,
    output logic [1:0]                dbg_state
);

    // Handshake: in_valid qualifies a beat only in ACC. done is a level held
    // until the controller answers with in_tile_reset; in_tile_reset in ACC is
    // an abort. in_all_done wins over everything and only reset_in leaves it.

    state_e              state_q, state_d;
    acc_t                acc_q [M_SIZE];
    acc_t                acc_d [M_SIZE];
    acc_t                acc_sum [M_SIZE];
    acc_t                beat_sum [M_SIZE];
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                done_d, valid_d, fin_d;
    logic [M_SIZE-1:0]   bits_d;
    logic [IDX_W-1:0]    hidx_d;
    logic                unused_top;

    // The window's top element never pairs with a feature.
    assign unused_top = in_projections[W_WIDTH-1];
    assign dbg_state  = state_q;

    for (genvar j = 0; j < M_SIZE; j++) begin : g_dim
        hd_beat_adder u_adder (
            .features (in_features),
            .weights  (in_projections[j +: N_SIZE]),
            .sum      (beat_sum[j])
        );
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = done;
        bits_d  = out_hv_bits;
        valid_d = 1'b0;
        hidx_d  = out_hv_index;
        fin_d   = finished;
        for (int j = 0; j < M_SIZE; j++)
            acc_sum[j] = acc_q[j] + beat_sum[j];

        if (in_all_done) begin
            state_d = FINISH;
            fin_d   = 1'b1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_tile_reset) begin
                        for (int j = 0; j < M_SIZE; j++)
                            acc_d[j] = '0;
                        cnt_d = '0;
                    end else if (in_valid) begin
                        acc_d = acc_sum;
                        if (cnt_q == BEAT_W'(BEATS-1)) begin
                            cnt_d   = '0;
                            state_d = DONE;
                            done_d  = 1'b1;
                            valid_d = 1'b1;
                            hidx_d  = idx_q;
                            // Non-negative sum (including zero) maps to 1.
                            for (int j = 0; j < M_SIZE; j++)
                                bits_d[j] = ~acc_sum[j][ACC_W-1];
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (in_tile_reset) begin
                        for (int j = 0; j < M_SIZE; j++)
                            acc_d[j] = '0;
                        done_d  = 1'b0;
                        idx_d   = (idx_q == IDX_W'(TILES-1)) ? '0 : idx_q + 1'b1;
                        state_d = ACC;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= ACC;
            for (int j = 0; j < M_SIZE; j++)
                acc_q[j] <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            done         <= 1'b0;
            out_hv_bits  <= '0;
            out_hv_valid <= 1'b0;
            out_hv_index <= '0;
            finished     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            done         <= done_d;
            out_hv_bits  <= bits_d;
            out_hv_valid <= valid_d;
            out_hv_index <= hidx_d;
            finished     <= fin_d;
        end
    end

endmodule

// File: tb/tb_hd_mac_tile.sv
// Directed bench for hd_mac_tile: table of full tiles plus abort, handshake,
// asynchronous reset, index wrap and end-of-stream sequences.
module tb_hd_mac_tile;
    import hd_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset_in = 1'b0;
    logic [W_WIDTH-1:0]        in_projections = '0;
    logic [N_SIZE*FTWIDTH-1:0] in_features = '0;
    logic                      in_valid = 1'b0;
    logic                      in_tile_reset = 1'b0;
    logic                      in_all_done = 1'b0;
    logic                      done;
    logic [M_SIZE-1:0]         out_hv_bits;
    logic                      out_hv_valid;
    logic [IDX_W-1:0]          out_hv_index;
    logic                      finished;
    logic [1:0]                dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    int pulse_cnt = 0;
    logic [IDX_W+M_SIZE-1:0] exp_q[$];
    logic [IDX_W+M_SIZE-1:0] mon_e;

    typedef struct {
        logic [W_WIDTH-1:0] proj;
        int                 mode;
        logic [M_SIZE-1:0]  exp_bits;
    } vec_t;
    vec_t vecs[7];

    hd_mac_tile dut (
        .clk            (clk),
        .reset_in       (reset_in),
        .in_projections (in_projections),
        .in_features    (in_features),
        .in_valid       (in_valid),
        .in_tile_reset  (in_tile_reset),
        .in_all_done    (in_all_done),
        .done           (done),
        .out_hv_bits    (out_hv_bits),
        .out_hv_valid   (out_hv_valid),
        .out_hv_index   (out_hv_index),
        .finished       (finished),
        .dbg_state      (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode 0: ramp (k mod 256), 1: zero, 2: constant 200, 3: constant 255
    function automatic logic [N_SIZE*FTWIDTH-1:0] feats(int mode, int b);
        logic [N_SIZE*FTWIDTH-1:0] f;
        f = '0;
        for (int i = 0; i < N_SIZE; i++) begin
            case (mode)
                0: f[i*FTWIDTH +: FTWIDTH] = FTWIDTH'((b*N_SIZE + i) % 256);
                2: f[i*FTWIDTH +: FTWIDTH] = FTWIDTH'(200);
                3: f[i*FTWIDTH +: FTWIDTH] = FTWIDTH'(255);
                default: f[i*FTWIDTH +: FTWIDTH] = '0;
            endcase
        end
        return f;
    endfunction

    // scoreboard on the output strobe
    always @(negedge clk) begin
        if (reset_in && out_hv_valid) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_hv: got idx %0d bits %0h expected none", out_hv_index, out_hv_bits);
            end else begin
                mon_e = exp_q.pop_front();
                check("hv_bits", 32'(out_hv_bits), 32'(mon_e[M_SIZE-1:0]));
                check("hv_index", 32'(out_hv_index), 32'(mon_e[IDX_W+M_SIZE-1:M_SIZE]));
            end
        end
    end

    task automatic drive_beats(int n, logic [W_WIDTH-1:0] proj, int mode);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            in_valid       = 1'b1;
            in_projections = proj;
            in_features    = feats(mode, b);
        end
    endtask

    task automatic run_tile(logic [W_WIDTH-1:0] proj, int mode, logic [M_SIZE-1:0] exp_bits, int exp_idx);
        exp_q.push_back({IDX_W'(exp_idx), exp_bits});
        drive_beats(BEATS, proj, mode);
        @(negedge clk);
        in_valid = 1'b0;
        check("done_rise", 32'(done), 1);
        check("hv_valid_pulse", 32'(out_hv_valid), 1);
        @(negedge clk);
        check("hv_valid_single", 32'(out_hv_valid), 0);
        check("done_hold", 32'(done), 1);
    endtask

    task automatic ack();
        @(negedge clk);
        in_tile_reset = 1'b1;
        @(negedge clk);
        in_tile_reset = 1'b0;
        check("done_drop", 32'(done), 0);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        reset_in = 1'b0;
        @(negedge clk);
        reset_in = 1'b1;
    endtask

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 0, 16'hFFFF};
        vecs[1] = '{32'h0000_0000, 0, 16'h0000};
        vecs[2] = '{32'h0000_0000, 1, 16'hFFFF};
        vecs[3] = '{32'h0000_FFFF, 2, 16'h01FF};
        vecs[4] = '{32'hFFFF_0000, 2, 16'hFF00};
        vecs[5] = '{32'hAAAA_AAAA, 2, 16'hFFFF};
        vecs[6] = '{32'h0000_00FF, 2, 16'h0001};

        // reset state
        #12;
        check("rst_done", 32'(done), 0);
        check("rst_bits", 32'(out_hv_bits), 0);
        check("rst_valid", 32'(out_hv_valid), 0);
        check("rst_index", 32'(out_hv_index), 0);
        check("rst_finished", 32'(finished), 0);
        check("rst_state", 32'(dbg_state), 32'(ACC));
        @(negedge clk);
        reset_in = 1'b1;

        // table of full tiles, index advancing with each acknowledge
        for (int v = 0; v < 7; v++) begin
            run_tile(vecs[v].proj, vecs[v].mode, vecs[v].exp_bits, v);
            ack();
        end

        // asynchronous reset at beat 20, between clock edges
        drive_beats(20, 32'hFFFF_FFFF, 0);
        @(posedge clk);
        #2 reset_in = 1'b0;
        #1;
        check("async_bits", 32'(out_hv_bits), 0);
        check("async_index", 32'(out_hv_index), 0);
        check("async_done", 32'(done), 0);
        check("async_state", 32'(dbg_state), 32'(ACC));
        in_valid = 1'b0;
        @(negedge clk);
        reset_in = 1'b1;

        // abort after 10 negative beats; abort beat itself also carries data
        pulse_cnt = 0;
        drive_beats(10, 32'h0000_0000, 3);
        @(negedge clk);
        in_tile_reset = 1'b1;
        @(negedge clk);
        in_tile_reset = 1'b0;
        in_valid = 1'b0;
        run_tile(32'hFFFF_0000, 2, 16'hFF00, 0);
        check("abort_pulses", 32'(pulse_cnt), 1);
        ack();

        // done held while beats are offered, then acknowledged
        run_tile(32'hFFFF_FFFF, 0, 16'hFFFF, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid       = 1'b1;
            in_projections = 32'h0;
            in_features    = feats(3, k);
            check("hold_done", 32'(done), 1);
            check("hold_valid", 32'(out_hv_valid), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_tile_reset = 1'b1;
        @(negedge clk);
        in_tile_reset = 1'b0;
        check("hold_drop", 32'(done), 0);

        // run to the last tile index and wrap
        for (int t = 2; t < TILES; t++) begin
            run_tile(W_WIDTH'($urandom()), 1, 16'hFFFF, t);
            ack();
        end
        run_tile(32'h0000_FFFF, 2, 16'h01FF, 0);

        // end-of-stream while in DONE, then sticky against other inputs
        @(negedge clk);
        in_all_done = 1'b1;
        @(negedge clk);
        in_all_done = 1'b0;
        check("fin_finished", 32'(finished), 1);
        check("fin_done", 32'(done), 0);
        check("fin_valid", 32'(out_hv_valid), 0);
        check("fin_bits_hold", 32'(out_hv_bits), 32'h01FF);
        check("fin_state", 32'(dbg_state), 32'(FINISH));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_tile_reset = 1'b1;
            in_valid = 1'b1;
            in_features = feats(2, k);
        end
        @(negedge clk);
        in_tile_reset = 1'b0;
        in_valid = 1'b0;
        check("fin_sticky", 32'(finished), 1);
        check("fin_done_low", 32'(done), 0);
        check("fin_state_hold", 32'(dbg_state), 32'(FINISH));
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
